fetch_pc_sequencer: RTL
=======================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns and sequences the uPOWER instruction-fetch program counter: boot vector, sequential PC+4, stall hold,
//  and redirects from branch/jump resolution. Sits between the Update_PC incrementer and instruction memory.
//  Drives the fetch address, a fetch-valid qualifier and a one-cycle flush pulse toward the IF/ID register.
// PARAMETERS
//  RESET_VEC   64'h0000_0000_0040_0000  PC value loaded on reset; first fetched address
//  TRAP_VEC    64'h0000_0000_0000_0700  PC loaded on misaligned-target trap (only with PC_TRAP_EN)
//  PC_STEP     4                        byte increment per sequential fetch
// PORTS
//  clk           in   1   clock, all state updates on rising edge
//  rst           in   1   asynchronous, active-low reset (0 = reset)
//  stall         in   1   hold PC; downstream cannot accept a new instruction
//  redirect      in   1   branch/jump resolved taken this cycle
//  redirect_pc   in   64  redirect target byte address
//  pc            out  64  current fetch address to instruction memory
//  fetch_valid   out  1   pc is a valid fetch this cycle
//  flush         out  1   one-cycle pulse: discard instruction in IF/ID
//  state_o       out  2   FSM state (debug/verification visibility)
//  trap          out  1   one-cycle misaligned-target trap pulse (tied 0 without PC_TRAP_EN)
//  epc           out  64  faulting redirect target (tied 0 without PC_TRAP_EN)
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_VEC, state=BOOT, fetch_valid=0, flush=0, trap=0, epc=0.
//  - States: BOOT=2'd0, RUN=2'd1, HOLD=2'd2, REDIR=2'd3.
//  - BOOT: one cycle after rst deasserts, pc stays RESET_VEC, fetch_valid=0; next RUN (HOLD if stall=1).
//  - Event priority each edge in RUN/HOLD/REDIR: redirect > stall > sequential.
//  - RUN: fetch_valid=1. redirect=1 -> pc<=redirect_pc, flush<=1, state<=REDIR. stall=1 -> pc held,
//    state<=HOLD. else pc<=pc+PC_STEP.
//  - HOLD: fetch_valid=1, pc held. stall=0 -> pc<=pc+PC_STEP, RUN. redirect wins over stall (-> REDIR).
//  - REDIR: bubble, fetch_valid=0, flush deasserts after exactly one cycle; next RUN, or HOLD if stall=1.
//    pc not incremented in REDIR; new target is fetched first cycle in RUN/HOLD.
//  - Back-to-back redirect (redirect=1 while in REDIR): accepted; pc<=new target, flush pulses again.
//  - Latency: redirect sampled at edge N -> pc=target and flush=1 in cycle N+1, target fetch_valid in N+2.
//  - Arithmetic: 64-bit unsigned, modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0, no flag.
//  - Alignment: redirect_pc[1:0]!=0 handled per CONFIGURATION; sequential pc always stays word aligned.
//  - rst asserted mid-operation (any state, mid-stall or mid-flush): immediate return to reset values.
//  - flush is registered (no combinational path from redirect); pc is registered.
// CONFIGURATION
//  PC_TRAP_EN undefined: misaligned redirect_pc loaded with bits [1:0] forced to 2'b00; trap=0, epc=0.
//  PC_TRAP_EN defined: misaligned redirect -> pc<=TRAP_VEC, epc<=redirect_pc, trap=1 for one cycle,
//    flush=1, state REDIR. Aligned redirects unchanged. epc holds until next trap or reset.
// TESTING
//  1 reset: rst=0 then 1 -> pc=0x400000 with fetch_valid=0 one cycle, then 0x400000,0x400004,0x400008 valid.
//  2 stall: stall=1 for 3 cycles at pc=0x400008 -> pc held 0x400008, state HOLD; release -> 0x40000C.
//  3 redirect: redirect=1, redirect_pc=0x500000 in RUN -> next cycle pc=0x500000, flush=1, fetch_valid=0;
//    following cycle fetch_valid=1, flush=0; then 0x500004.
//  4 redirect+stall same cycle -> redirect wins; REDIR then HOLD with pc=target held until stall=0.
//  5 wrap: force pc=64'hFFFF_FFFF_FFFF_FFFC via redirect -> next sequential pc=0; rst=0 mid-REDIR -> reset values.
//  6 misaligned redirect_pc=0x500002: without PC_TRAP_EN pc=0x500000; with it pc=0x700, trap=1, epc=0x500002.

Source files
------------

// File: rtl/fetch_pc_sequencer_if.sv
// fetch_pc_sequencer_if: fetch control/redirect inputs and PC/fetch outputs of the fetch PC sequencer
interface fetch_pc_sequencer_if;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic [1:0]  state_o;
  logic        trap;
  logic [63:0] epc;
  modport master (output stall, redirect, redirect_pc, input pc, fetch_valid, flush, state_o, trap, epc);
  modport slave (input stall, redirect, redirect_pc, output pc, fetch_valid, flush, state_o, trap, epc);
endinterface

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: boot/sequential/stall/redirect fetch PC sequencer; define PC_TRAP_EN to trap misaligned redirects
module fetch_pc_sequencer #(
  parameter logic [63:0] RESET_VEC = 64'h0000_0000_0040_0000,
  parameter logic [63:0] TRAP_VEC  = 64'h0000_0000_0000_0700,
  parameter logic [63:0] PC_STEP   = 64'd4
) (
  input logic clk,
  input logic rst,
  fetch_pc_sequencer_if.slave s
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2, REDIR = 2'd3} state_t;
  state_t state, state_d;
  logic [63:0] pc, pc_d, tgt;
  logic flush, flush_d, take;
`ifdef PC_TRAP_EN
  logic trap, trap_d, mis;
  logic [63:0] epc, epc_d;
`endif
  // Next state, next pc and pulse outputs; redirect beats stall beats sequential outside BOOT
  always_comb begin
    take = (state != BOOT) && s.redirect;
`ifdef PC_TRAP_EN
    mis = |s.redirect_pc[1:0];
    tgt = mis ? TRAP_VEC : s.redirect_pc;
    trap_d = take && mis;
    epc_d = trap_d ? s.redirect_pc : epc;
`else
    tgt = s.redirect_pc & ~64'd3;
`endif
    flush_d = take;
    state_d = state == BOOT ? (s.stall ? HOLD : RUN) : take ? REDIR : s.stall ? HOLD : RUN;
    pc_d = take ? tgt : (state == BOOT || state == REDIR || s.stall) ? pc : pc + PC_STEP;
  end
  // State, pc and pulse registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc <= RESET_VEC;
      flush <= 1'b0;
`ifdef PC_TRAP_EN
      trap <= 1'b0;
      epc <= '0;
`endif
    end else begin
      state <= state_d;
      pc <= pc_d;
      flush <= flush_d;
`ifdef PC_TRAP_EN
      trap <= trap_d;
      epc <= epc_d;
`endif
    end
  end
  assign s.pc = pc;
  assign s.flush = flush;
  assign s.state_o = state;
  assign s.fetch_valid = state == RUN || state == HOLD;
`ifdef PC_TRAP_EN
  assign s.trap = trap;
  assign s.epc = epc;
`else
  assign s.trap = 1'b0;
  assign s.epc = '0;
`endif
endmodule
